// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding memory request, a one-entry
// output buffer toward decode, and redirect handling that drops stale responses.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_FETCH | may issue a request for pc_q once the output buffer is empty
// ST_WAIT  | one request outstanding; drop_q marks its response as stale
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_WAIT  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic        buf_valid, buf_valid_d;
    logic [31:0] buf_inst, buf_inst_d;
    logic [31:0] buf_pc, buf_pc_d;

    logic        req_fire;
    logic        out_fire;
    logic [31:0] redirect_target;

    assign imem_req_valid_o = (state_q == ST_FETCH) && !buf_valid;
    assign imem_addr_o      = pc_q;
    assign inst_valid_o     = buf_valid;
    assign inst_o           = buf_inst;
    assign pc_o             = buf_pc;

    assign req_fire        = imem_req_valid_o && imem_req_ready_i;
    assign out_fire        = buf_valid && inst_ready_i;
    assign redirect_target = redirect_pc_i & ~32'h0000_0003;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            drop_q    <= 1'b0;
            buf_valid <= 1'b0;
            buf_inst  <= 32'h0000_0000;
            buf_pc    <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            drop_q    <= drop_d;
            buf_valid <= buf_valid_d;
            buf_inst  <= buf_inst_d;
            buf_pc    <= buf_pc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        buf_valid_d = buf_valid && !out_fire;
        buf_inst_d  = buf_inst;
        buf_pc_d    = buf_pc;

        if (redirect_i) begin
            // A request accepted or still in flight this cycle belongs to the
            // old path, so its response must never reach the buffer.
            pc_d        = redirect_target;
            buf_valid_d = 1'b0;
            case (state_q)
                ST_FETCH: begin
                    if (req_fire) begin
                        state_d = ST_WAIT;
                        drop_d  = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid_i) begin
                        state_d = ST_FETCH;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (req_fire) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid_i) begin
                        state_d = ST_FETCH;
                        if (drop_q) begin
                            drop_d = 1'b0;
                        end else begin
                            buf_valid_d = 1'b1;
                            buf_inst_d  = imem_rsp_data_i;
                            buf_pc_d    = pc_q;
                            pc_d        = pc_q + 32'd4;
                        end
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a behavioural memory plus an instruction
// stream scoreboard predict every handshake and output value.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] pc_o;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_addr_o      (imem_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_o           (inst_o),
        .pc_o             (pc_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // expected decode-side buffer and the next address the unit should fetch
    bit          exp_buf;
    logic [31:0] exp_buf_pc;
    logic [31:0] exp_buf_inst;
    logic [31:0] exp_next;
    bit          addr_chk;
    logic [31:0] addr_chk_val;
    int          emitted;

    // memory: a single pending slot, stale after a reset abandoned it
    bit          mem_busy;
    bit          mem_stale;
    bit          mem_wanted;
    int          mem_cnt;
    logic [31:0] mem_addr;

    bit rdy_rand;
    int lat_min;
    int lat_max;
    int iready_mode;
    bit spurious_en;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0050_0093;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input bit rst, input bit redir, input logic [31:0] rpc);
        bit          exp_req;
        bit          rdy;
        bit          rsp;
        bit          rsp_hit;
        bit          iready;
        bit          acc;
        logic [31:0] rdata;
        logic [31:0] tgt;

        exp_req = !exp_buf && !(mem_busy && !mem_stale);
        check("inst_valid", {31'd0, inst_valid_o}, {31'd0, exp_buf});
        if (exp_buf) begin
            check("pc_o", pc_o, exp_buf_pc);
            check("inst_o", inst_o, exp_buf_inst);
        end
        check("req_valid", {31'd0, imem_req_valid_o}, {31'd0, exp_req});
        if (imem_req_valid_o) check("addr_align", imem_addr_o & 32'h3, 32'h0);
        if (addr_chk) check("addr_after_event", imem_addr_o, addr_chk_val);
        addr_chk = 0;

        rdy = (mem_busy || rst) ? 1'b0 : (rdy_rand ? 1'($urandom_range(1, 0)) : 1'b1);
        rsp_hit = mem_busy && (mem_cnt == 0);
        if (rsp_hit) begin
            rsp   = 1'b1;
            rdata = mem_fn(mem_addr);
        end else if (!mem_busy && spurious_en && ($urandom_range(7, 0) == 0)) begin
            rsp   = 1'b1;
            rdata = $urandom;
        end else begin
            rsp   = 1'b0;
            rdata = $urandom;
        end
        case (iready_mode)
            1:       iready = 1'b1;
            2:       iready = 1'b0;
            default: iready = 1'($urandom_range(1, 0));
        endcase

        rst_i            = rst;
        imem_req_ready_i = rdy;
        imem_rsp_valid_i = rsp;
        imem_rsp_data_i  = rdata;
        redirect_i       = redir;
        redirect_pc_i    = rpc;
        inst_ready_i     = iready;

        acc = exp_req && rdy;
        if (!rst) begin
            if (exp_buf && iready) begin
                exp_buf = 0;
                emitted++;
            end
            if (rsp_hit && !mem_stale && mem_wanted && !redir) begin
                exp_buf      = 1;
                exp_buf_pc   = mem_addr;
                exp_buf_inst = mem_fn(mem_addr);
                exp_next     = mem_addr + 32'd4;
            end
        end
        if (rsp_hit) begin
            mem_busy  = 0;
            mem_stale = 0;
        end else if (mem_busy) begin
            mem_cnt--;
        end
        if (rst) begin
            exp_buf      = 0;
            exp_next     = RESET_PC;
            mem_wanted   = 0;
            if (mem_busy) mem_stale = 1;
            addr_chk     = 1;
            addr_chk_val = RESET_PC;
        end else begin
            if (acc) begin
                check("req_addr", imem_addr_o, exp_next);
                mem_busy   = 1;
                mem_stale  = 0;
                mem_addr   = imem_addr_o;
                mem_cnt    = $urandom_range(lat_max, lat_min);
                mem_wanted = !redir;
            end
            if (redir) begin
                tgt          = rpc & ~32'h3;
                exp_buf      = 0;
                exp_next     = tgt;
                mem_wanted   = 0;
                addr_chk     = 1;
                addr_chk_val = tgt;
            end
        end
        @(negedge clk_i);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0);
    endtask

    task automatic run_until_busy(input int budget);
        int n = 0;
        while (!(mem_busy && !mem_stale) && n < budget) begin
            cycle(1'b0, 1'b0, 32'h0);
            n++;
        end
        check("wait_busy_timeout", {31'd0, mem_busy && !mem_stale}, 32'd1);
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((mem_busy || exp_buf) && n < budget) begin
            cycle(1'b0, 1'b0, 32'h0);
            n++;
        end
        check("wait_idle_timeout", {31'd0, !mem_busy && !exp_buf}, 32'd1);
    endtask

    initial begin
        rst_i = 1'b1; imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i = 32'h0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        inst_ready_i = 1'b0;
        exp_buf = 0; exp_buf_pc = 0; exp_buf_inst = 0; exp_next = RESET_PC;
        addr_chk = 0; addr_chk_val = 0; emitted = 0;
        mem_busy = 0; mem_stale = 0; mem_wanted = 0; mem_cnt = 0; mem_addr = 0;
        rdy_rand = 0; lat_min = 0; lat_max = 0; iready_mode = 1; spurious_en = 0;
        @(negedge clk_i);
        @(negedge clk_i);

        // straight-line fetch, 1-cycle memory, decoder always ready
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        run(9);
        check("seq_emitted", {31'd0, emitted >= 2}, 32'd1);

        // decoder stall then drain
        iready_mode = 2;
        run(8);
        iready_mode = 1;
        run(6);

        // redirect while waiting, response three cycles after acceptance
        lat_min = 2; lat_max = 2;
        run_until_busy(20);
        cycle(1'b0, 1'b1, 32'h0000_0103);
        run(12);

        // redirect in the same cycle as a response
        lat_min = 0; lat_max = 0;
        run_until_busy(20);
        cycle(1'b0, 1'b1, 32'h0000_0206);
        run(8);

        // redirect in the same cycle as a request handshake
        run_until_idle(20);
        cycle(1'b0, 1'b1, 32'h0000_0301);
        run(10);

        // PC wrap past the top of the address space
        run_until_idle(20);
        cycle(1'b0, 1'b1, 32'hFFFF_FFFE);
        run(10);

        // reset during WAIT, late response lands just after release
        lat_min = 1; lat_max = 1;
        run_until_busy(20);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        run(10);

        // randomized traffic
        rdy_rand = 1; lat_min = 0; lat_max = 3; iready_mode = 0; spurious_en = 1;
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(299, 0) == 0), ($urandom_range(11, 0) == 0), $urandom);
        end
        check("emitted_total", {31'd0, emitted > 50}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
